cond_queue: RTL and testbench

COND_QUEUE -- requirements
Module: cond_queue

---
 rtl/cond_queue.sv | 158 +++++++++++++++
 tb/tb_cond_queue.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_queue.sv
// cond_queue: condition-gated issue queue; entries wait until all condition bits are set,
// then the oldest ready entry is offered. Ports: enq_* (write), wake_* (condition set), deq_* (oldest ready), count.
module cond_queue #(
   parameter int DEPTH           = 8,
   parameter int DATA_WIDTH      = 32,
   parameter int CONDITION_WIDTH = 2,
   parameter int INDEX_WIDTH     = 4
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       flush,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic [DATA_WIDTH-1:0]      enq_data,
   input  logic [CONDITION_WIDTH-1:0] enq_condition,
   input  logic [INDEX_WIDTH-1:0]     enq_index,
   output logic [$clog2(DEPTH)-1:0]   enq_slot,
   input  logic                       wake_valid,
   input  logic [$clog2(DEPTH)-1:0]   wake_slot,
   input  logic [CONDITION_WIDTH-1:0] wake_mask,
   output logic                       deq_valid,
   input  logic                       deq_ready,
   output logic [DATA_WIDTH-1:0]      deq_data,
   output logic [INDEX_WIDTH-1:0]     deq_index,
   output logic [$clog2(DEPTH)-1:0]   deq_slot,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int SW = $clog2(DEPTH);
   localparam logic [SW:0] FULL = (SW+1)'(DEPTH);

   logic [DEPTH-1:0]           valid_q, valid_d;
   logic [DATA_WIDTH-1:0]      data_q  [DEPTH];
   logic [DATA_WIDTH-1:0]      data_d  [DEPTH];
   logic [CONDITION_WIDTH-1:0] cond_q  [DEPTH];
   logic [CONDITION_WIDTH-1:0] cond_d  [DEPTH];
   logic [INDEX_WIDTH-1:0]     index_q [DEPTH];
   logic [INDEX_WIDTH-1:0]     index_d [DEPTH];
   // older_q[i][j] set: slot i was enqueued before slot j
   logic [DEPTH-1:0]           older_q [DEPTH];
   logic [DEPTH-1:0]           older_d [DEPTH];
   logic [SW:0]                count_q, count_d;

   logic [DEPTH-1:0] ready;
   logic [DEPTH-1:0] grant;
   logic             enq_fire;
   logic             deq_fire;

   assign count     = count_q;
   assign enq_ready = (count_q < FULL);
   assign enq_fire  = enq_valid & enq_ready & ~flush;
   assign deq_fire  = deq_valid & deq_ready & ~flush;

   always_comb begin
      enq_slot = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) enq_slot = SW'(i);
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ready[i] = valid_q[i] & (&cond_q[i]);
      end
   end

   // Age order is total over valid slots, so grant is one-hot and the OR-mux is safe.
   always_comb begin
      grant     = '0;
      deq_valid = 1'b0;
      deq_data  = '0;
      deq_index = '0;
      deq_slot  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant[i] = ready[i];
         for (int j = 0; j < DEPTH; j++) begin
            if (j != i && ready[j] && older_q[j][i]) grant[i] = 1'b0;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (grant[i]) begin
            deq_valid = 1'b1;
            deq_data  = deq_data | data_q[i];
            deq_index = deq_index | index_q[i];
            deq_slot  = deq_slot | SW'(i);
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      count_d = count_q + (SW+1)'(enq_fire) - (SW+1)'(deq_fire);
      for (int i = 0; i < DEPTH; i++) begin
         data_d[i]  = data_q[i];
         cond_d[i]  = cond_q[i];
         index_d[i] = index_q[i];
         older_d[i] = older_q[i];
      end
      // The slot being filled is still invalid here, so a wake to it is dropped.
      if (wake_valid && valid_q[wake_slot]) begin
         cond_d[wake_slot] = cond_q[wake_slot] | wake_mask;
      end
      if (enq_fire) begin
         valid_d[enq_slot] = 1'b1;
         data_d[enq_slot]  = enq_data;
         cond_d[enq_slot]  = enq_condition;
         index_d[enq_slot] = enq_index;
         older_d[enq_slot] = '0;
         for (int j = 0; j < DEPTH; j++) begin
            older_d[j][enq_slot] = valid_q[j];
         end
      end
      // Clearing last lets it override a wake to the same slot.
      if (deq_fire) begin
         valid_d[deq_slot] = 1'b0;
         data_d[deq_slot]  = '0;
         cond_d[deq_slot]  = '0;
         index_d[deq_slot] = '0;
         older_d[deq_slot] = '0;
         for (int j = 0; j < DEPTH; j++) begin
            older_d[j][deq_slot] = 1'b0;
         end
      end
      if (flush) begin
         valid_d = '0;
         count_d = '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_d[i]  = '0;
            cond_d[i]  = '0;
            index_d[i] = '0;
            older_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i]  <= '0;
            cond_q[i]  <= '0;
            index_q[i] <= '0;
            older_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i]  <= data_d[i];
            cond_q[i]  <= cond_d[i];
            index_q[i] <= index_d[i];
            older_q[i] <= older_d[i];
         end
      end
   end

endmodule

// File: tb/tb_cond_queue.sv
// tb_cond_queue: randomized and directed stimulus for cond_queue, checked against
// a sequence-number reference model through a scoreboard monitor.
module tb_cond_queue;

   logic        clock;
   logic        reset_n;
   logic        flush;
   logic        enq_valid;
   logic        enq_ready;
   logic [31:0] enq_data;
   logic [1:0]  enq_condition;
   logic [3:0]  enq_index;
   logic [2:0]  enq_slot;
   logic        wake_valid;
   logic [2:0]  wake_slot;
   logic [1:0]  wake_mask;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_data;
   logic [3:0]  deq_index;
   logic [2:0]  deq_slot;
   logic [3:0]  count;

   cond_queue dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .flush         (flush),
      .enq_valid     (enq_valid),
      .enq_ready     (enq_ready),
      .enq_data      (enq_data),
      .enq_condition (enq_condition),
      .enq_index     (enq_index),
      .enq_slot      (enq_slot),
      .wake_valid    (wake_valid),
      .wake_slot     (wake_slot),
      .wake_mask     (wake_mask),
      .deq_valid     (deq_valid),
      .deq_ready     (deq_ready),
      .deq_data      (deq_data),
      .deq_index     (deq_index),
      .deq_slot      (deq_slot),
      .count         (count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0]  cnt;
      logic        er;
      logic [2:0]  es;
      logic        dv;
      logic [31:0] dd;
      logic [3:0]  di;
      logic [2:0]  ds;
   } st_t;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  ix;
      logic [2:0]  sl;
   } dq_t;

   st_t st_q[$];
   dq_t dq_q[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 0;

   bit          mv   [8];
   logic [1:0]  mc   [8];
   logic [31:0] md   [8];
   logic [3:0]  mi   [8];
   int unsigned mseq [8];
   int unsigned seq_ctr = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 8; i++) begin
         mv[i] = 0; mc[i] = '0; md[i] = '0; mi[i] = '0; mseq[i] = 0;
      end
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         if (st_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL status_avail actual=empty required=entry");
         end else begin
            st_t e;
            e = st_q.pop_front();
            chk("count", count, e.cnt);
            chk("enq_ready", enq_ready, e.er);
            chk("enq_slot", enq_slot, e.es);
            chk("deq_valid", deq_valid, e.dv);
            chk("deq_data_out", deq_data, e.dd);
            chk("deq_index_out", deq_index, e.di);
            chk("deq_slot_out", deq_slot, e.ds);
         end
         if (deq_valid && deq_ready && !flush) begin
            if (dq_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL deq_unexpected slot=%0d required=none", deq_slot);
            end else begin
               dq_t d;
               d = dq_q.pop_front();
               chk("deq_data", deq_data, d.d);
               chk("deq_index", deq_index, d.ix);
               chk("deq_slot", deq_slot, d.sl);
            end
         end
      end
   end

   task automatic step(input bit ev, input logic [1:0] ec, input bit wv,
                       input logic [2:0] ws, input logic [1:0] wm,
                       input bit dr, input bit fl);
      int   n;
      int   sel;
      int   es;
      bit   er, ef, df;
      st_t  e;
      dq_t  d;
      @(posedge clock);
      #1;
      enq_valid     = ev;
      enq_condition = ec;
      enq_data      = $urandom;
      enq_index     = 4'($urandom_range(0, 15));
      wake_valid    = wv;
      wake_slot     = ws;
      wake_mask     = wm;
      deq_ready     = dr;
      flush         = fl;
      n = 0; es = -1; sel = -1;
      for (int i = 0; i < 8; i++) begin
         if (mv[i]) n++;
         else if (es < 0) es = i;
         if (mv[i] && mc[i] == 2'b11 && (sel < 0 || mseq[i] < mseq[sel])) sel = i;
      end
      er = (n < 8);
      e = '0;
      e.cnt = 4'(n);
      e.er  = er;
      e.es  = (es < 0) ? 3'd0 : 3'(es);
      e.dv  = (sel >= 0);
      if (sel >= 0) begin
         e.dd = md[sel]; e.di = mi[sel]; e.ds = 3'(sel);
      end
      mon_en = 1;
      st_q.push_back(e);
      ef = ev && er && !fl;
      df = (sel >= 0) && dr && !fl;
      if (df) begin
         d.d = md[sel]; d.ix = mi[sel]; d.sl = 3'(sel);
         dq_q.push_back(d);
      end
      if (fl) begin
         model_clear();
      end else begin
         if (wv && mv[ws]) mc[ws] = mc[ws] | wm;
         if (df) begin
            mv[sel] = 0; mc[sel] = '0; md[sel] = '0; mi[sel] = '0;
         end
         if (ef) begin
            mv[es] = 1; mc[es] = ec; md[es] = enq_data; mi[es] = enq_index;
            mseq[es] = seq_ctr++;
         end
      end
   endtask

   task automatic idle_inputs();
      enq_valid = 0; enq_condition = '0; enq_data = '0; enq_index = '0;
      wake_valid = 0; wake_slot = '0; wake_mask = '0;
      deq_ready = 0; flush = 0;
   endtask

   task automatic do_reset();
      @(posedge clock);
      #1;
      mon_en = 0;
      idle_inputs();
      #2;
      reset_n = 0;
      #1;
      chk("rst_count", count, 4'd0);
      chk("rst_deq_valid", deq_valid, 1'b0);
      chk("rst_enq_ready", enq_ready, 1'b1);
      chk("rst_enq_slot", enq_slot, 3'd0);
      chk("rst_deq_data", deq_data, 32'd0);
      chk("rst_deq_slot", deq_slot, 3'd0);
      model_clear();
      @(posedge clock);
      #3;
      reset_n = 1;
   endtask

   initial begin
      reset_n = 1;
      idle_inputs();
      model_clear();
      #1 reset_n = 0;
      #2;
      chk("init_count", count, 4'd0);
      chk("init_enq_ready", enq_ready, 1'b1);
      chk("init_enq_slot", enq_slot, 3'd0);
      chk("init_deq_valid", deq_valid, 1'b0);
      chk("init_deq_data", deq_data, 32'd0);
      #9 reset_n = 1;

      // in-order drain of two ready entries
      step(1, 2'b11, 0, 3'd0, 2'b00, 0, 0);
      step(1, 2'b11, 0, 3'd0, 2'b00, 0, 0);
      repeat (3) step(0, 2'b00, 0, 3'd0, 2'b00, 1, 0);

      // younger ready entry bypasses older waiting one, then wake
      step(1, 2'b01, 0, 3'd0, 2'b00, 0, 0);
      step(1, 2'b11, 0, 3'd0, 2'b00, 0, 0);
      step(0, 2'b00, 0, 3'd0, 2'b00, 1, 0);
      step(0, 2'b00, 1, 3'd0, 2'b10, 0, 0);
      step(0, 2'b00, 0, 3'd0, 2'b00, 1, 0);
      step(0, 2'b00, 0, 3'd0, 2'b00, 1, 0);

      // fill, hold enq_valid while full, wake+dequeue same slot
      step(0, 2'b00, 0, 3'd0, 2'b00, 0, 1);
      repeat (8) step(1, 2'b00, 0, 3'd0, 2'b00, 0, 0);
      repeat (2) step(1, 2'b11, 0, 3'd0, 2'b00, 1, 0);
      step(0, 2'b00, 1, 3'd3, 2'b11, 0, 0);
      step(0, 2'b00, 1, 3'd3, 2'b11, 1, 0);
      step(1, 2'b11, 1, 3'd3, 2'b11, 0, 0);
      step(0, 2'b00, 0, 3'd0, 2'b00, 1, 0);

      // flush overrides a pending enqueue
      step(0, 2'b00, 0, 3'd0, 2'b00, 0, 1);
      repeat (5) step(1, 2'b11, 0, 3'd0, 2'b00, 0, 0);
      step(1, 2'b11, 0, 3'd0, 2'b00, 1, 1);
      step(0, 2'b00, 0, 3'd0, 2'b00, 0, 0);

      // asynchronous reset with three entries held
      repeat (3) step(1, 2'b01, 0, 3'd0, 2'b00, 0, 0);
      do_reset();
      step(0, 2'b00, 0, 3'd0, 2'b00, 1, 0);

      for (int c = 0; c < 600; c++) begin
         if (c == 300) do_reset();
         step($urandom_range(0, 4) < 3, 2'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
              $urandom_range(0, 49) == 0);
      end

      step(0, 2'b00, 0, 3'd0, 2'b00, 0, 0);
      @(posedge clock);
      #1;
      mon_en = 0;
      chk("deq_drain", 64'(dq_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
